// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared definitions for the pipeline hazard controller:
//               FSM state encodings, register-zero constant and the default
//               memory-wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Controller FSM states (also exported on the debug state port)
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_LUSTALL = 2'd3
    } state_t;

    // Architectural register $zero never creates a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default number of frozen cycles tolerated before a memory timeout
    localparam int DEF_MEM_TIMEOUT = 16;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator. Flags when the load in EX
//               writes a non-zero register read by the instruction in ID.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_ex_rt,
    input  logic       id_ex_memread,
    output logic       lu
);

    logic w_src_match;

    // Either ID source operand matches the destination of the load in EX
    always_comb begin
        w_src_match = (id_ex_rt == id_rs) || (id_ex_rt == id_rt);
        lu          = id_ex_memread && (id_ex_rt != REG_ZERO) && w_src_match;
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencing controller for the 5-stage MIPS core.
//               Registered FSM with Mealy outputs handling load-use stalls,
//               taken-branch flushes and data-memory wait with timeout.
//               Optional performance counters enabled by defining
//               HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = 8
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rt,
    input  logic        mem_pcsrc,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        freeze,
    output logic        mem_err,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(MEM_TIMEOUT);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_cnt_next;
    logic               r_mem_err;
    logic               w_err_set;
    logic               w_lu;
    logic               w_mw;

    hazard_detect u_detect (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_ex_rt      (id_ex_rt),
        .id_ex_memread (id_ex_memread),
        .lu            (w_lu)
    );

    assign w_mw    = dmem_req && !dmem_ready;
    assign state   = r_state;
    assign mem_err = r_mem_err;

    // Next-state and Mealy control outputs; reset forces the RUN-idle pattern
    always_comb begin
        w_next          = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_err_set       = 1'b0;
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        id_ex_bubble    = 1'b0;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;
        flush_ex_mem    = 1'b0;
        freeze          = 1'b0;

        case (r_state)
            ST_MEMWAIT: begin
                if (dmem_ready) begin
                    w_next          = ST_RUN;
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt >= c_timeout) begin
                    // Abandon the access and let the pipe run again
                    w_err_set       = 1'b1;
                    w_next          = ST_RUN;
                    w_wait_cnt_next = '0;
                end else begin
                    freeze          = 1'b1;
                    pc_write        = 1'b0;
                    if_id_write     = 1'b0;
                    w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                // RUN, FLUSH and LUSTALL share the priority chain; only RUN
                // honours a load-use hazard since the other two hold a NOP
                // or bubble in the consuming stage.
                w_next = ST_RUN;
                if (w_mw) begin
                    freeze          = 1'b1;
                    pc_write        = 1'b0;
                    if_id_write     = 1'b0;
                    w_next          = ST_MEMWAIT;
                    w_wait_cnt_next = CNT_W'(1);
                end else if (mem_pcsrc) begin
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    w_next       = ST_FLUSH;
                end else if (w_lu && (r_state == ST_RUN)) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    w_next       = ST_LUSTALL;
                end
            end
        endcase

        if (rst) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
            flush_ex_mem = 1'b0;
            freeze       = 1'b0;
        end
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic        w_in_chain;
    logic        w_lu_acc;
    logic        w_br_acc;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    assign w_in_chain = (r_state != ST_MEMWAIT);
    assign w_br_acc   = w_in_chain && !w_mw && mem_pcsrc;
    assign w_lu_acc   = (r_state == ST_RUN) && !w_mw && !mem_pcsrc && w_lu;

    // Saturating event counters for accepted stalls and flushes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lu_acc && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_br_acc && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed-vector scoreboard bench for hazard_ctrl. The driver
//               pushes hand-computed expectations per cycle; a monitor pops
//               and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit c_perf = 1'b1;
`else
    localparam bit c_perf = 1'b0;
`endif

    // {pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, freeze}
    localparam logic [6:0] c_idle  = 7'b1100000;
    localparam logic [6:0] c_stall = 7'b0010000;
    localparam logic [6:0] c_flush = 7'b1101110;
    localparam logic [6:0] c_frz   = 7'b0000001;

    typedef struct {
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic        err;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_ex_rt;
    logic        id_ex_memread, mem_pcsrc, dmem_req, dmem_ready;
    logic        pc_write, if_id_write, id_ex_bubble;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, freeze, mem_err;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_ex_memread (id_ex_memread),
        .id_ex_rt      (id_ex_rt),
        .mem_pcsrc     (mem_pcsrc),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .id_ex_bubble  (id_ex_bubble),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .flush_ex_mem  (flush_ex_mem),
        .freeze        (freeze),
        .mem_err       (mem_err),
        .state         (state),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    // Apply one cycle of inputs just after the rising edge and queue its expectation
    task automatic vec(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] exrt, input logic pc,
                       input logic rq, input logic rd, input logic [6:0] ctl,
                       input logic [1:0] st, input logic err, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; id_ex_memread = mr; id_ex_rt = exrt;
        mem_pcsrc = pc; dmem_req = rq; dmem_ready = rd;
        e.ctl = ctl;
        e.st  = st;
        e.err = err;
        e.sc  = c_perf ? 16'(sc) : 16'd0;
        e.fc  = c_perf ? 16'(fc) : 16'd0;
        q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle, checked mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = q.pop_front();
            act = {pc_write, if_id_write, id_ex_bubble, flush_if_id,
                   flush_id_ex, flush_ex_mem, freeze};
            n_cmp += 5;
            if (act !== e.ctl) begin
                n_bad++;
                $display("FAIL ctl @%0t: got %b expected %b", $time, act, e.ctl);
            end
            if (state !== e.st) begin
                n_bad++;
                $display("FAIL state @%0t: got %0d expected %0d", $time, state, e.st);
            end
            if (mem_err !== e.err) begin
                n_bad++;
                $display("FAIL mem_err @%0t: got %b expected %b", $time, mem_err, e.err);
            end
            if (stall_cnt !== e.sc) begin
                n_bad++;
                $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, stall_cnt, e.sc);
            end
            if (flush_cnt !== e.fc) begin
                n_bad++;
                $display("FAIL flush_cnt @%0t: got %0d expected %0d", $time, flush_cnt, e.fc);
            end
        end
    end

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_ex_memread = 1'b0; id_ex_rt = '0;
        mem_pcsrc = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        @(posedge clk);
        //   rst rs  rt  mr exrt pc rq rd  ctl      st err sc fc
        vec(1, 0,  0,  0, 0,   0, 0, 0, c_idle,  0, 0, 0, 0); // reset state
        // load-use stall, then bubble cycle
        vec(0, 8,  3,  1, 8,   0, 0, 0, c_stall, 0, 0, 0, 0);
        vec(0, 0,  0,  0, 0,   0, 0, 0, c_idle,  3, 0, 1, 0);
        vec(0, 0,  0,  0, 0,   0, 0, 0, c_idle,  0, 0, 1, 0);
        // $zero never stalls
        vec(0, 0,  0,  1, 0,   0, 0, 0, c_idle,  0, 0, 1, 0);
        // branch with simultaneous load-use: flush wins
        vec(0, 8,  8,  1, 8,   1, 0, 0, c_flush, 0, 0, 1, 0);
        vec(0, 0,  0,  0, 0,   0, 0, 0, c_idle,  2, 0, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 0, 0, c_idle,  0, 0, 1, 1);
        // memory wait: 3 frozen cycles then ready
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_frz,   0, 0, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_frz,   1, 0, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_frz,   1, 0, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 1, 1, c_idle,  1, 0, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 0, 0, c_idle,  0, 0, 1, 1);
        // timeout with MEM_TIMEOUT=4: 4 frozen cycles then abandon
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_frz,   0, 0, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_frz,   1, 0, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_frz,   1, 0, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_frz,   1, 0, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_idle,  1, 0, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 0, 0, c_idle,  0, 1, 1, 1);
        // wait together with branch: freeze first, branch on exit
        vec(0, 0,  0,  0, 0,   1, 1, 0, c_frz,   0, 1, 1, 1);
        vec(0, 0,  0,  0, 0,   1, 1, 1, c_idle,  1, 1, 1, 1);
        vec(0, 0,  0,  0, 0,   1, 0, 0, c_flush, 0, 1, 1, 1);
        vec(0, 0,  0,  0, 0,   0, 0, 0, c_idle,  2, 1, 1, 2);
        // reset on cycle 2 of MEMWAIT
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_frz,   0, 1, 1, 2);
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_frz,   1, 1, 1, 2);
        vec(1, 0,  0,  0, 0,   0, 1, 0, c_idle,  1, 1, 1, 2);
        vec(0, 0,  0,  0, 0,   0, 0, 0, c_idle,  0, 0, 0, 0);
        // load-use, then memory wait during the bubble cycle
        vec(0, 5,  9,  1, 9,   0, 0, 0, c_stall, 0, 0, 0, 0);
        vec(0, 0,  0,  0, 0,   0, 1, 0, c_frz,   3, 0, 1, 0);
        vec(0, 0,  0,  0, 0,   0, 1, 1, c_idle,  1, 0, 1, 0);
        vec(0, 0,  0,  0, 0,   0, 0, 0, c_idle,  0, 0, 1, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
